// File: rtl/ddrx_init_pkg.sv
// Shared types and constants for the DDR3 power-up/initialisation sequencer.
package ddrx_init_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WAIT_PHY,
    ST_RST_HOLD,
    ST_CKE_WAIT,
    ST_XPR_WAIT,
    ST_MRS,
    ST_ZQCL,
    ST_ZQ_WAIT,
    ST_CALIB,
    ST_DONE
  } init_state_e;

  typedef struct packed {
    logic cs_n;
    logic ras_n;
    logic cas_n;
    logic we_n;
  } dfi_cmd_t;

  localparam dfi_cmd_t CMD_DES  = '{cs_n: 1'b1, ras_n: 1'b1, cas_n: 1'b1, we_n: 1'b1};
  localparam dfi_cmd_t CMD_MRS  = '{cs_n: 1'b0, ras_n: 1'b0, cas_n: 1'b0, we_n: 1'b0};
  localparam dfi_cmd_t CMD_ZQCL = '{cs_n: 1'b0, ras_n: 1'b1, cas_n: 1'b1, we_n: 1'b0};

  // A10 high selects ZQCL (long calibration) rather than ZQCS.
  localparam logic [15:0] ZQCL_ADDR = 16'h0400;

  // Mode registers go out in JEDEC init order: MR2, MR3, MR1, MR0.
  localparam logic [2:0] MR_ORDER [4] = '{3'd2, 3'd3, 3'd1, 3'd0};

  // Timer preload for a T-cycle dwell; T=0 is treated as a single cycle.
  function automatic int unsigned wait_load(input int unsigned t_cyc);
    return (t_cyc == 0) ? 0 : t_cyc - 1;
  endfunction

endpackage

// File: rtl/init_wait_timer.sv
// Down-counting dwell timer: load a preload value, count to zero, flag expiry.
module init_wait_timer #(
  parameter int CNT_W = 18
) (
  input  logic             core_clk,
  input  logic             core_arstn,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] count;

  // Load on request, otherwise decrement and park at zero.
  always_ff @(posedge core_clk or negedge core_arstn) begin
    if (!core_arstn) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/dram_init_sequencer.sv
// DDR3 power-up/initialisation sequencer. Drives RESET#/CKE, MR2/MR3/MR1/MR0,
// ZQCL on the DFI command bus, then hands off to calibration.
// Build option: DDRX_INIT_FAST_SIM_EN shortens RESET# hold and CKE wait to 16 cycles.
//
// state        | meaning
// -------------+-------------------------------------------------------------
// ST_IDLE      | waiting for init_start
// ST_WAIT_PHY  | waiting for dfi_init_complete
// ST_RST_HOLD  | RESET# held low for the reset dwell
// ST_CKE_WAIT  | RESET# high, CKE low for the CKE dwell
// ST_XPR_WAIT  | CKE high, waiting tXPR before first MRS
// ST_MRS       | MRS issued on entry/re-trigger; dwell tMRD (tMOD after MR0)
// ST_ZQCL      | ZQCL on the bus this cycle
// ST_ZQ_WAIT   | waiting tZQinit
// ST_CALIB     | calib_start high until calib_done
// ST_DONE      | terminal; init_done high, bus idle
module dram_init_sequencer
  import ddrx_init_pkg::*;
#(
  parameter int unsigned T_RST_CYC    = 80000,
  parameter int unsigned T_CKE_CYC    = 200000,
  parameter int unsigned T_XPR_CYC    = 108,
  parameter int unsigned T_MRD_CYC    = 4,
  parameter int unsigned T_MOD_CYC    = 12,
  parameter int unsigned T_ZQINIT_CYC = 512,
  parameter int          CNT_W        = 18
) (
  input  logic        core_clk,
  input  logic        core_arstn,
  input  logic        init_start,
  input  logic        dfi_init_complete,
  input  logic [15:0] mr0,
  input  logic [15:0] mr1,
  input  logic [15:0] mr2,
  input  logic [15:0] mr3,
  input  logic        calib_done,
  output logic        calib_start,
  output logic        init_done,
  output logic        dfi_reset_n,
  output logic        dfi_cke,
  output logic        dfi_cs_n,
  output logic        dfi_ras_n,
  output logic        dfi_cas_n,
  output logic        dfi_we_n,
  output logic [2:0]  dfi_bank,
  output logic [15:0] dfi_address,
  output logic        dfi_odt
);

`ifdef DDRX_INIT_FAST_SIM_EN
  localparam int unsigned RST_EFF = 16;
  localparam int unsigned CKE_EFF = 16;
`else
  localparam int unsigned RST_EFF = T_RST_CYC;
  localparam int unsigned CKE_EFF = T_CKE_CYC;
`endif

  localparam logic [CNT_W-1:0] LD_RST = CNT_W'(wait_load(RST_EFF));
  localparam logic [CNT_W-1:0] LD_CKE = CNT_W'(wait_load(CKE_EFF));
  localparam logic [CNT_W-1:0] LD_XPR = CNT_W'(wait_load(T_XPR_CYC));
  localparam logic [CNT_W-1:0] LD_MRD = CNT_W'(wait_load(T_MRD_CYC));
  localparam logic [CNT_W-1:0] LD_MOD = CNT_W'(wait_load(T_MOD_CYC));
  localparam logic [CNT_W-1:0] LD_ZQ  = CNT_W'(wait_load(T_ZQINIT_CYC));

  init_state_e      state_q, state_d;
  logic [1:0]       mr_idx_q, mr_idx_d;
  logic             timer_load;
  logic [CNT_W-1:0] timer_val;
  logic             timer_expired;

  dfi_cmd_t         cmd_q, cmd_d;
  logic [2:0]       bank_q, bank_d;
  logic [15:0]      addr_q, addr_d;
  logic             reset_n_q, reset_n_d;
  logic             cke_q, cke_d;
  logic             calib_start_q, calib_start_d;
  logic             init_done_q, init_done_d;

  // MRS target for the next issue: index 0 when leaving XPR_WAIT, else the following slot.
  logic [1:0]       mrs_idx;
  logic [2:0]       mrs_bank;
  logic [15:0]      mrs_addr;

  init_wait_timer #(
    .CNT_W(CNT_W)
  ) u_wait_timer (
    .core_clk  (core_clk),
    .core_arstn(core_arstn),
    .load      (timer_load),
    .load_val  (timer_val),
    .expired   (timer_expired)
  );

  // Pick the bank and mode-register value for the MRS about to be issued.
  always_comb begin
    mrs_idx  = (state_q == ST_XPR_WAIT) ? mr_idx_q : mr_idx_q + 2'd1;
    mrs_bank = MR_ORDER[mrs_idx];
    mrs_addr = 16'h0000;
    case (mrs_bank)
      3'd0:    mrs_addr = mr0;
      3'd1:    mrs_addr = mr1;
      3'd2:    mrs_addr = mr2;
      3'd3:    mrs_addr = mr3;
      default: mrs_addr = 16'h0000;
    endcase
  end

  // Next-state, timer control and next registered output values.
  always_comb begin
    state_d       = state_q;
    mr_idx_d      = mr_idx_q;
    timer_load    = 1'b0;
    timer_val     = '0;
    cmd_d         = CMD_DES;
    bank_d        = 3'd0;
    addr_d        = 16'h0000;
    reset_n_d     = reset_n_q;
    cke_d         = cke_q;
    calib_start_d = 1'b0;
    init_done_d   = init_done_q;

    case (state_q)
      ST_IDLE: begin
        if (init_start) state_d = ST_WAIT_PHY;
      end
      ST_WAIT_PHY: begin
        if (dfi_init_complete) begin
          state_d    = ST_RST_HOLD;
          timer_load = 1'b1;
          timer_val  = LD_RST;
        end
      end
      ST_RST_HOLD: begin
        if (timer_expired) begin
          reset_n_d  = 1'b1;
          state_d    = ST_CKE_WAIT;
          timer_load = 1'b1;
          timer_val  = LD_CKE;
        end
      end
      ST_CKE_WAIT: begin
        if (timer_expired) begin
          cke_d      = 1'b1;
          state_d    = ST_XPR_WAIT;
          timer_load = 1'b1;
          timer_val  = LD_XPR;
        end
      end
      ST_XPR_WAIT: begin
        if (timer_expired) begin
          state_d    = ST_MRS;
          mr_idx_d   = mrs_idx;
          cmd_d      = CMD_MRS;
          bank_d     = mrs_bank;
          addr_d     = mrs_addr;
          timer_load = 1'b1;
          timer_val  = (mrs_idx == 2'd3) ? LD_MOD : LD_MRD;
        end
      end
      ST_MRS: begin
        if (timer_expired) begin
          // Index wraps 3->0 so a later re-run starts at MR2 again.
          mr_idx_d = mr_idx_q + 2'd1;
          if (mr_idx_q == 2'd3) begin
            state_d = ST_ZQCL;
            cmd_d   = CMD_ZQCL;
            addr_d  = ZQCL_ADDR;
          end else begin
            cmd_d      = CMD_MRS;
            bank_d     = mrs_bank;
            addr_d     = mrs_addr;
            timer_load = 1'b1;
            timer_val  = (mrs_idx == 2'd3) ? LD_MOD : LD_MRD;
          end
        end
      end
      ST_ZQCL: begin
        state_d    = ST_ZQ_WAIT;
        timer_load = 1'b1;
        timer_val  = LD_ZQ;
      end
      ST_ZQ_WAIT: begin
        if (timer_expired) begin
          state_d       = ST_CALIB;
          calib_start_d = 1'b1;
        end
      end
      ST_CALIB: begin
        if (calib_done) begin
          init_done_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          calib_start_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, MRS index and all DFI/handshake outputs are registered here.
  always_ff @(posedge core_clk or negedge core_arstn) begin
    if (!core_arstn) begin
      state_q       <= ST_IDLE;
      mr_idx_q      <= 2'd0;
      cmd_q         <= CMD_DES;
      bank_q        <= 3'd0;
      addr_q        <= 16'h0000;
      reset_n_q     <= 1'b0;
      cke_q         <= 1'b0;
      calib_start_q <= 1'b0;
      init_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      mr_idx_q      <= mr_idx_d;
      cmd_q         <= cmd_d;
      bank_q        <= bank_d;
      addr_q        <= addr_d;
      reset_n_q     <= reset_n_d;
      cke_q         <= cke_d;
      calib_start_q <= calib_start_d;
      init_done_q   <= init_done_d;
    end
  end

  assign dfi_cs_n    = cmd_q.cs_n;
  assign dfi_ras_n   = cmd_q.ras_n;
  assign dfi_cas_n   = cmd_q.cas_n;
  assign dfi_we_n    = cmd_q.we_n;
  assign dfi_bank    = bank_q;
  assign dfi_address = addr_q;
  assign dfi_reset_n = reset_n_q;
  assign dfi_cke     = cke_q;
  assign dfi_odt     = 1'b0;
  assign calib_start = calib_start_q;
  assign init_done   = init_done_q;

endmodule

// File: tb/tb_dram_init_sequencer.sv
// Directed bench for dram_init_sequencer with shortened timing parameters.
// Honours DDRX_INIT_FAST_SIM_EN when the design is built with it.
`timescale 1ns/1ps
module tb_dram_init_sequencer;

`ifdef DDRX_INIT_FAST_SIM_EN
  localparam int TB_RST  = 80000;
  localparam int TB_CKE  = 200000;
  localparam int EXP_RST = 16;
  localparam int EXP_CKE = 16;
`else
  localparam int TB_RST  = 10;
  localparam int TB_CKE  = 20;
  localparam int EXP_RST = 10;
  localparam int EXP_CKE = 20;
`endif
  localparam int TB_XPR = 5;
  localparam int TB_MRD = 4;
  localparam int TB_MOD = 12;
  localparam int TB_ZQ  = 8;

  logic        core_clk = 1'b0;
  logic        core_arstn;
  logic        init_start;
  logic        dfi_init_complete;
  logic [15:0] mr0, mr1, mr2, mr3;
  logic        calib_done;
  logic        calib_start, init_done;
  logic        dfi_reset_n, dfi_cke;
  logic        dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n;
  logic [2:0]  dfi_bank;
  logic [15:0] dfi_address;
  logic        dfi_odt;

  dram_init_sequencer #(
    .T_RST_CYC   (TB_RST),
    .T_CKE_CYC   (TB_CKE),
    .T_XPR_CYC   (TB_XPR),
    .T_MRD_CYC   (TB_MRD),
    .T_MOD_CYC   (TB_MOD),
    .T_ZQINIT_CYC(TB_ZQ),
    .CNT_W       (18)
  ) dut (
    .core_clk         (core_clk),
    .core_arstn       (core_arstn),
    .init_start       (init_start),
    .dfi_init_complete(dfi_init_complete),
    .mr0              (mr0),
    .mr1              (mr1),
    .mr2              (mr2),
    .mr3              (mr3),
    .calib_done       (calib_done),
    .calib_start      (calib_start),
    .init_done        (init_done),
    .dfi_reset_n      (dfi_reset_n),
    .dfi_cke          (dfi_cke),
    .dfi_cs_n         (dfi_cs_n),
    .dfi_ras_n        (dfi_ras_n),
    .dfi_cas_n        (dfi_cas_n),
    .dfi_we_n         (dfi_we_n),
    .dfi_bank         (dfi_bank),
    .dfi_address      (dfi_address),
    .dfi_odt          (dfi_odt)
  );

  always #5 core_clk = ~core_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Bus recorder: cycle stamps of edges and every command seen on the bus.
  int          cyc = 0;
  int          rn_cyc, cke_cyc, cs_cnt, cs_first, done_cyc;
  int          des_bad = 0, odt_bad = 0;
  logic        prev_rn = 1'b0, prev_cke = 1'b0, prev_done = 1'b0;
  int          q_cyc[$];
  logic [3:0]  q_cmd[$];
  logic [2:0]  q_bank[$];
  logic [15:0] q_addr[$];

  always @(posedge core_clk) begin
    #1;
    cyc++;
    if (!dfi_cs_n) begin
      q_cyc.push_back(cyc);
      q_cmd.push_back({dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n});
      q_bank.push_back(dfi_bank);
      q_addr.push_back(dfi_address);
    end else if ({dfi_ras_n, dfi_cas_n, dfi_we_n} != 3'b111 || dfi_bank != 3'd0 || dfi_address != 16'h0)
      des_bad++;
    if (dfi_odt) odt_bad++;
    if (dfi_reset_n && !prev_rn && rn_cyc < 0) rn_cyc = cyc;
    if (dfi_cke && !prev_cke && cke_cyc < 0) cke_cyc = cyc;
    if (init_done && !prev_done && done_cyc < 0) done_cyc = cyc;
    if (calib_start) begin
      if (cs_cnt == 0) cs_first = cyc;
      cs_cnt++;
    end
    prev_rn   = dfi_reset_n;
    prev_cke  = dfi_cke;
    prev_done = init_done;
  end

  task automatic clear_rec();
    q_cyc.delete(); q_cmd.delete(); q_bank.delete(); q_addr.delete();
    rn_cyc = -1; cke_cyc = -1; cs_cnt = 0; cs_first = -1; done_cyc = -1;
  endtask

  task automatic check_idle_outputs(input string t);
    check({t, "_reset_n"}, dfi_reset_n, 0);
    check({t, "_cke"}, dfi_cke, 0);
    check({t, "_cmd"}, {dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n}, 4'hF);
    check({t, "_bank"}, dfi_bank, 0);
    check({t, "_addr"}, dfi_address, 0);
    check({t, "_odt"}, dfi_odt, 0);
    check({t, "_calib_start"}, calib_start, 0);
    check({t, "_init_done"}, init_done, 0);
  endtask

  task automatic wait_done(input int budget, input string t);
    for (int i = 0; i < budget; i++) begin
      if (init_done) break;
      @(negedge core_clk);
    end
    check(t, init_done, 1);
  endtask

  // p is the cycle RST_HOLD is entered; all command stamps are derived from it.
  task automatic check_seq(input int p, input string t);
    int base;
    logic [2:0]  exp_bank [4];
    logic [15:0] exp_addr [4];
    exp_bank = '{3'd2, 3'd3, 3'd1, 3'd0};
    exp_addr = '{16'h0018, 16'h0000, 16'h0044, 16'h1D70};
    base = p + EXP_RST + EXP_CKE;
    check({t, "_reset_n_rise"}, rn_cyc, p + EXP_RST);
    check({t, "_cke_rise"}, cke_cyc, base);
    check({t, "_cmd_count"}, q_cyc.size(), 5);
    if (q_cyc.size() == 5) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("%s_mrs%0d_cyc", t, i), q_cyc[i], base + TB_XPR + TB_MRD * i);
        check($sformatf("%s_mrs%0d_cmd", t, i), q_cmd[i], 4'b0000);
        check($sformatf("%s_mrs%0d_bank", t, i), q_bank[i], exp_bank[i]);
        check($sformatf("%s_mrs%0d_addr", t, i), q_addr[i], exp_addr[i]);
      end
      check({t, "_zqcl_cyc"}, q_cyc[4], base + TB_XPR + 3 * TB_MRD + TB_MOD);
      check({t, "_zqcl_cmd"}, q_cmd[4], 4'b0110);
      check({t, "_zqcl_bank"}, q_bank[4], 0);
      check({t, "_zqcl_addr"}, q_addr[4], 16'h0400);
    end
    check({t, "_calib_start_cyc"}, cs_first, base + TB_XPR + 3 * TB_MRD + TB_MOD + 1 + TB_ZQ);
  endtask

  initial begin
    int p, c;
    core_arstn = 1'b0; init_start = 1'b0; dfi_init_complete = 1'b0; calib_done = 1'b1;
    mr0 = 16'h1D70; mr1 = 16'h0044; mr2 = 16'h0018; mr3 = 16'h0000;
    clear_rec();
    repeat (3) @(negedge core_clk);
    check_idle_outputs("por");
    core_arstn = 1'b1;
    repeat (2) @(negedge core_clk);

    // Run 1: PHY not ready for 50 cycles, calib_done stuck high throughout.
    init_start = 1'b1;
    repeat (50) @(negedge core_clk);
    check("phy_wait_reset_n", dfi_reset_n, 0);
    check("phy_wait_cmds", q_cyc.size(), 0);
    check("phy_wait_calib_start", calib_start, 0);
    dfi_init_complete = 1'b1;
    p = cyc + 1;
    @(negedge core_clk);
    init_start = 1'b0;
    wait_done(300, "r1_done_seen");
    check_seq(p, "r1");
    check("r1_calib_start_len", cs_cnt, 1);
    check("r1_done_cyc", done_cyc, cs_first + 1);

    // DONE is terminal: PHY drop and a new init_start change nothing.
    dfi_init_complete = 1'b0;
    init_start = 1'b1;
    repeat (10) @(negedge core_clk);
    check("done_hold_init_done", init_done, 1);
    check("done_hold_reset_n", dfi_reset_n, 1);
    check("done_hold_cke", dfi_cke, 1);
    check("done_hold_no_cmds", q_cyc.size(), 5);
    check("done_hold_calib_start", calib_start, 0);
    init_start = 1'b0;

    core_arstn = 1'b0;
    #1;
    check_idle_outputs("done_arst");

    // Run 2: reset pulse after MR3 has gone out.
    @(negedge core_clk);
    core_arstn = 1'b1;
    clear_rec();
    calib_done = 1'b0;
    dfi_init_complete = 1'b1;
    @(negedge core_clk);
    init_start = 1'b1;
    @(negedge core_clk);
    init_start = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (q_cyc.size() >= 2) break;
      @(negedge core_clk);
    end
    check("r2_mr3_seen", q_cyc.size(), 2);
    core_arstn = 1'b0;
    #1;
    check_idle_outputs("mrs_arst");
    repeat (2) @(negedge core_clk);
    check("mrs_arst_no_cmds", q_cyc.size(), 2);
    core_arstn = 1'b1;
    clear_rec();

    // Run 3: full re-run, calib_done held off for 5 cycles into CALIB.
    @(negedge core_clk);
    init_start = 1'b1;
    p = cyc + 2;
    @(negedge core_clk);
    init_start = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (cs_cnt > 0) break;
      @(negedge core_clk);
    end
    check("r3_calib_start_seen", (cs_cnt > 0), 1);
    c = cs_first;
    repeat (5) @(negedge core_clk);
    check("r3_calib_start_held", calib_start, 1);
    check("r3_not_done_yet", init_done, 0);
    calib_done = 1'b1;
    wait_done(20, "r3_done_seen");
    check_seq(p, "r3");
    check("r3_calib_start_len", cs_cnt, 6);
    check("r3_done_cyc", done_cyc, c + 6);
    @(negedge core_clk);
    check("r3_calib_start_low", calib_start, 0);

    check("des_idle_clean", des_bad, 0);
    check("odt_always_low", odt_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
